// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: store funct3 codes, default depth
// and the layout of one buffered store entry.
package store_buffer_pkg;

    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    localparam int SB_DEPTH_DEFAULT = 4;

    // One buffered store: word address, lane-positioned data, byte strobes.
    // The valid bit lives in a separate vector so that only it needs reset.
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  strb;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Load forwarding: merges buffered store bytes over the RAM read word.
// For every byte lane the youngest valid matching entry wins.
module store_buffer_fwd
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
)
(
    input  sb_entry_t                  entries [DEPTH],
    input  logic [DEPTH-1:0]           entry_valid,
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [29:0]                word_addr,
    input  logic [31:0]                ram_rdata,
    output logic [31:0]                fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk entries oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        fwd_data = ram_rdata;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (entry_valid[idx] && (entries[idx].waddr == word_addr)) begin
                for (int k = 0; k < 4; k++) begin
                    if (entries[idx].strb[k]) begin
                        fwd_data[8*k +: 8] = entries[idx].data[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and the data RAM. Accepted stores are
// queued in a circular FIFO and drained one per ram_wready; loads see the
// buffered bytes merged over the RAM word.
// Handshake: ram_wreq is held with stable head address/data/strobe until a
// cycle where ram_wreq and ram_wready are both 1; the head retires on that edge.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_write,
    input  logic [2:0]  write_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_read,
    output logic [31:0] mem_read_data,
    output logic        stall,
    output logic        misaligned,
    output logic        empty,
    output logic [31:0] ram_raddr,
    input  logic [31:0] ram_rdata,
    output logic        ram_wreq,
    output logic [31:0] ram_waddr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    input  logic        ram_wready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic      is_sb, is_sh, is_sw, is_store, addr_bad, full, enq, deq;
    sb_entry_t new_entry;
    logic [31:0] fwd_data;

    // Qualify the incoming store: width decode, alignment and capacity.
    always_comb begin
        is_sb      = (write_type == FUNCT3_SB);
        is_sh      = (write_type == FUNCT3_SH);
        is_sw      = (write_type == FUNCT3_SW);
        is_store   = ram_write && (is_sb || is_sh || is_sw);
        addr_bad   = (is_sh && mem_addr[0]) || (is_sw && (mem_addr[1:0] != 2'b00));
        full       = (count == CNT_W'(DEPTH));
        misaligned = rst && is_store && addr_bad;
        stall      = rst && is_store && !addr_bad && full;
        enq        = is_store && !addr_bad && !full;
        deq        = (count != '0) && ram_wready;
    end

    // Position store data on byte lanes and build the matching strobe.
    always_comb begin
        new_entry.waddr = mem_addr[31:2];
        new_entry.data  = mem_write_data;
        new_entry.strb  = 4'b1111;
        if (is_sb) begin
            new_entry.data = {4{mem_write_data[7:0]}};
            new_entry.strb = 4'b0001 << mem_addr[1:0];
        end else if (is_sh) begin
            new_entry.data = {2{mem_write_data[15:0]}};
            new_entry.strb = mem_addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Entry payload storage; contents are qualified by entry_valid, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= new_entry;
        end
    end

    // FIFO pointers, occupancy and valid bits; reset discards pending stores.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (enq) begin
                tail              <= tail + PTR_W'(1);
                entry_valid[tail] <= 1'b1;
            end
            if (deq) begin
                head              <= head + PTR_W'(1);
                entry_valid[head] <= 1'b0;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // RAM-side and status outputs.
    always_comb begin
        ram_wreq      = (count != '0);
        empty         = (count == '0);
        ram_waddr     = {entries[head].waddr, 2'b00};
        ram_wdata     = entries[head].data;
        ram_wstrb     = entries[head].strb;
        ram_raddr     = {mem_addr[31:2], 2'b00};
        mem_read_data = mem_read ? fwd_data : 32'h0;
    end

    store_buffer_fwd #(.DEPTH(DEPTH)) u_fwd (
        .entries     (entries),
        .entry_valid (entry_valid),
        .head        (head),
        .word_addr   (mem_addr[31:2]),
        .ram_rdata   (ram_rdata),
        .fwd_data    (fwd_data)
    );

endmodule
